// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: conditions start/stop and lap/clear buttons, prescales the
// count enable for a BCD digit chain, and manages lap freeze, clear and overflow.
module stopwatch_ctrl #(
    parameter int DIV = 4,
    parameter int PW  = $clog2(DIV)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_btn,
    input  logic       lap_btn,
    input  logic       top_carry,
    output logic       tick_en,
    output logic       cnt_clr,
    output logic       disp_hold,
    output logic [1:0] state,
    output logic       overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        LAP   = 2'b10,
        PAUSE = 2'b11
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          ovf_q, ovf_d;

    // Bit 0 = first synchronizer flop, bit 1 = second, bit 2 = edge-detect flop.
    logic [2:0] start_sync, lap_sync;
    logic       start_ev, lap_ev, counting, ovf_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_sync <= '0;
            lap_sync   <= '0;
            state_q    <= IDLE;
            presc_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            start_sync <= {start_sync[1:0], start_btn};
            lap_sync   <= {lap_sync[1:0], lap_btn};
            state_q    <= state_d;
            presc_q    <= presc_d;
            ovf_q      <= ovf_d;
        end
    end

    assign start_ev = start_sync[1] & ~start_sync[2];
    assign lap_ev   = lap_sync[1] & ~lap_sync[2];
    assign counting = (state_q == RUN) || (state_q == LAP);
    assign tick_en  = counting && (presc_q == PW'(DIV - 1));
    assign ovf_hit  = tick_en && top_carry;

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        ovf_d   = ovf_q;
        cnt_clr = 1'b0;

        if (counting) begin
            presc_d = (presc_q == PW'(DIV - 1)) ? '0 : presc_q + 1'b1;
        end else if (state_q == IDLE) begin
            presc_d = '0;
        end

        // A wrapping tick forces PAUSE and swallows any button event this cycle.
        if (ovf_hit) begin
            state_d = PAUSE;
            ovf_d   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_ev) begin
                        state_d = RUN;
                    end else if (lap_ev) begin
                        cnt_clr = 1'b1;
                        ovf_d   = 1'b0;
                    end
                end
                RUN: begin
                    if (start_ev) begin
                        state_d = PAUSE;
                    end else if (lap_ev) begin
                        state_d = LAP;
                    end
                end
                LAP: begin
                    if (start_ev) begin
                        state_d = PAUSE;
                    end else if (lap_ev) begin
                        state_d = RUN;
                    end
                end
                PAUSE: begin
                    if (start_ev) begin
                        state_d = RUN;
                    end else if (lap_ev) begin
                        state_d = IDLE;
                        cnt_clr = 1'b1;
                        presc_d = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign disp_hold = (state_q == LAP);
    assign state     = state_q;
    assign overflow  = ovf_q;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Sequencing controller for a chain of BCD digit counters (unit digit up to top digit).
- Turns two push-button levels into start/stop and lap/clear actions.
- Generates the count-enable pulse that feeds c_in of the least-significant digit, plus the synchronous clear for the chain.
- Also drives a display-freeze flag for lap mode and flags overflow from the most-significant digit's carry.

Parameters:
- DIV, 4, prescaler ratio: one count enable every DIV clocks while counting. Legal range: DIV >= 2.
- PW, $clog2(DIV), prescaler register width. Derived; do not override.

Ports:
- clk  input  1  system clock, all flops rising-edge.
- reset  input  1  asynchronous active-low reset. Asserted (0) forces all state immediately.
- start_btn  input  1  start/stop button level, asynchronous to clk.
- lap_btn  input  1  lap/clear button level, asynchronous to clk.
- top_carry  input  1  carry out of the most-significant digit. Combinational with tick_en in the same cycle.
- tick_en  output  1  one-cycle count enable to the least-significant digit's c_in.
- cnt_clr  output  1  one-cycle synchronous clear to every digit's reset.
- disp_hold  output  1  high while the displayed value must stay frozen (lap).
- state  output  2  FSM state: IDLE=00, RUN=01, LAP=10, PAUSE=11.
- overflow  output  1  sticky: count wrapped past its maximum.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; prescaler=0; sync/edge flops=0; overflow=0.
  - tick_en=0, cnt_clr=0, disp_hold=0.
  - Reset asserted mid-count aborts immediately; no tick_en or cnt_clr is emitted during or on release of reset.
- Button conditioning (per button):
  - Path is 2-flop synchronizer s1 -> s2, then edge flop s3.
  - Event ev = s2 & ~s3, lasting exactly one cycle per press.
  - With the input high before edge k, ev is high between edges k+1 and k+2; the FSM acts at edge k+2.
  - A held button produces one event only. Release produces no event.
- Simultaneous events: start_ev and lap_ev in the same cycle -> start_ev wins, lap_ev is discarded.
- FSM transitions (evaluated at the clock edge):
  - IDLE:
    - start_ev -> RUN.
    - lap_ev -> stay IDLE, cnt_clr=1 for that cycle, overflow cleared.
  - RUN:
    - start_ev -> PAUSE.
    - lap_ev -> LAP.
  - LAP:
    - start_ev -> PAUSE.
    - lap_ev -> RUN (display released).
  - PAUSE:
    - start_ev -> RUN.
    - lap_ev -> IDLE, cnt_clr=1 for that cycle, prescaler cleared to 0, overflow cleared.
- Prescaler:
  - Advances on every edge where the current state is RUN or LAP: increments, wrapping from DIV-1 to 0.
  - Holds its value in PAUSE.
  - Held at 0 in IDLE.
  - Resuming from PAUSE continues from the frozen value, so no partial period is lost or duplicated.
- tick_en:
  - Combinational: (state==RUN or LAP) and prescaler==DIV-1.
  - Registered inputs only, so it is glitch-free per cycle.
  - Exactly one pulse per DIV counting cycles; the first pulse comes DIV cycles after entering RUN from IDLE.
  - If the state leaves RUN/LAP on the same edge that tick_en is high, that tick still counts: the digits sample it on that edge.
- cnt_clr:
  - Combinational decode of the current state and lap_ev, per the IDLE and PAUSE rows above.
  - Never high in the same cycle as tick_en: IDLE and PAUSE have no ticks.
- disp_hold: 1 iff state==LAP. The display latch captures the digits on the rising edge of disp_hold.
- Overflow:
  - When tick_en=1 and top_carry=1 in the same cycle: overflow<=1 and state<=PAUSE on that edge.
  - The digit chain wraps to all-zero on its own.
  - This takes priority over start_ev/lap_ev in that cycle, which are discarded.
  - overflow stays set until a cnt_clr cycle or reset.
  - start_ev from PAUSE with overflow=1 resumes counting; the flag stays set.
- Outputs never take X after reset release.

Test Plan:
- Reset/idle, DIV=4: hold reset=0 3 cycles then release, no buttons -> state=00, tick_en, cnt_clr, disp_hold, overflow all 0 for 20 cycles.
- Start counting: raise start_btn and hold -> state=01 at the 3rd edge; tick_en pulses on cycles 4, 8, 12 after entry; a 2-digit chain reads 03 after 12 cycles; holding the button gives no further events.
- Pause/resume: pause with prescaler=2 -> no tick_en for 10 cycles, prescaler stays 2; press start -> first tick 2 cycles after RUN re-entry.
- Lap: in RUN press lap -> state=10, disp_hold=1, ticks continue; press lap again -> state=01, disp_hold=0.
- Clear: from PAUSE press lap -> cnt_clr high exactly 1 cycle, state=00, digits=00, prescaler=0.
- Overflow and simultaneous events, DIV=4, 2-digit chain:
  - Preload 99 in RUN -> next tick gives top_carry=1, overflow=1, state=11, digits=00.
  - Press both buttons in the same cycle -> start action only (state=01), no cnt_clr.
  - Then press lap, then start, then lap (reaching PAUSE) -> overflow cleared.
